fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the pipelined MIPS core.
- Owns the PC register and computes the next fetch address: sequential, beq-style branch, j, or jr.
- Drives a req/ack instruction-memory port and owns the IF/ID pipeline register.
- Honours ID-stage stalls and the single architectural delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- stall_i  in  1  hazard stall; ID holds its instruction.
- redirect_sel  in  2  from ID: 00 none, 01 branch taken, 10 j, 11 jr.
- br_imm  in  16  raw branch offset (instr[15:0]).
- j_idx  in  26  jump index (instr[25:0]).
- rs_val  in  32  forwarded rs value, used for jr.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  IF/ID holds a live instruction.
- id_instr  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID instruction address.
- fetch_exc  out  1  misaligned-fetch flag; only with the optional feature.

Behaviour:
- Reset (async, reset_n=0):
  - pc_q=RESET_PC, state IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=0, id_pc=RESET_PC, fetch_exc=0.
  - Buffer and redirect-pending cleared.
  - Reset mid-request abandons the request; an ack arriving in IDLE is ignored.
- FSM states:
  - IDLE: imem_req=0 → REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc_q.
  - HOLD: fetched word buffered, imem_req=0.
- REQ:
  - Address held stable until imem_ack.
  - On ack with IF/ID free (id_valid=0 or stall_i=0): id_instr=imem_rdata, id_pc=pc_q, id_valid=1, pc_q advances; stay in REQ.
  - Zero-wait memory (ack in the request cycle) gives 1 instruction/cycle.
  - On ack with IF/ID stalled: word and address go to the buffer, pc_q advances, → HOLD.
- HOLD: when stall_i=0, buffer → IF/ID (id_valid=1) at that edge, → REQ.
- Bubble: if ID consumes (id_valid=1, stall_i=0) and nothing is loaded that edge, id_valid→0 and id_instr→0.
- Stall: id_valid=1 and stall_i=1 freezes id_instr and id_pc.
- Next-address arithmetic (32-bit, wrap mod 2^32; p4 = id_pc+4):
  - sequential: pc_q+4.
  - branch: p4 + (sign_extend(br_imm)<<2).
  - j: {p4[31:28], j_idx, 2'b00}.
  - jr: rs_val.
- Redirect sampling:
  - Sampled only at edges where id_valid=1, stall_i=0 and redirect_sel≠0.
  - Target is computed from the current id_pc.
  - The delay slot (id_pc+4) is always fetched and delivered.
  - If the slot is accepted at or before this edge (ack this edge, or already buffered): pc_q←target immediately.
  - Otherwise, the slot fetch is in flight: latch target and set pend. On the slot's ack, pc_q←target instead of +4, and pend clears.
  - Invariant: id_pc+8 is never requested before the redirect resolves.
  - A redirect while pend=1 (branch in delay slot) is ignored.
- Simultaneous events:
  - Ack, redirect and stall release at one edge are all applied.
  - Redirect has priority over the sequential pc_q update.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - A redirect target with [1:0]≠0 is not fetched.
  - The next IF/ID load gets id_instr=0 (nop), id_pc=target, and fetch_exc=1 for that instruction.
  - pc_q stays at the target and the FSM parks in IDLE until reset.
- Not defined:
  - fetch_exc is tied to 0.
  - Targets are used as-is; the low bits go to imem_addr.

Test Plan:
1. Reset release with zero-wait ack always high → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; id_pc follows one cycle later; id_valid=1 from the 2nd cycle.
2. Branch at id_pc=0x3010, redirect_sel=01, br_imm=16'hFFFC → delay slot 0x3014 delivered, next fetch 0x3004; 0x3018 never requested.
3. j at 0x3000, j_idx=26'h0000C10 → slot 0x3004, then fetch 0x00003040. jr with rs_val=0x3100 → fetch 0x3100 after the slot.
4. Ack delayed 3 cycles during redirect → pend set; the slot's ack loads pc_q=target; imem_addr stable while waiting.
5. stall_i held 4 cycles with a word acked → HOLD, imem_req=0, id_instr unchanged; release → buffered word in IF/ID next edge, fetch resumes at buffered addr+4.
6. reset_n pulsed low mid-request → outputs at reset values immediately; late ack ignored; fetch restarts at 0x3000. With FETCH_ALIGN_CHK_EN, jr to 0x3102 → nop with fetch_exc=1, no further imem_req.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Instruction-memory request/acknowledge port of the fetch sequencer.
// The sequencer holds imem_addr stable from request until imem_ack.
interface fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC, next-address select, imem req/ack, IF/ID register.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect targets become a flagged nop and fetch parks.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic [1:0]         redirect_sel,
    input  logic [15:0]        br_imm,
    input  logic [25:0]        j_idx,
    input  logic [31:0]        rs_val,
    fetch_seq_if.master        imem,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc,
    output logic               fetch_exc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_pend;
    logic [31:0] r_tgt;

    logic [31:0] w_p4;
    logic [31:0] w_br_off;
    logic [31:0] w_target;
    logic        w_ack;
    logic        w_id_free;
    logic        w_consume;
    logic        w_redir;
    logic        w_load_mem;
    logic        w_load_buf;
    logic        w_load_nop;
    logic        w_resolve;
    logic [31:0] w_resolve_tgt;
    logic        w_set_pend;
    logic        w_misalign;
    logic        w_park;

    assign w_p4     = r_id_pc + 32'd4;
    assign w_br_off = {{14{br_imm[15]}}, br_imm, 2'b00};

    always_comb begin
        w_target = w_p4;
        case (redirect_sel)
            2'b01:   w_target = w_p4 + w_br_off;
            2'b10:   w_target = {w_p4[31:28], j_idx, 2'b00};
            2'b11:   w_target = rs_val;
            default: w_target = w_p4;
        endcase
    end

    assign w_ack      = (r_state == ST_REQ) && imem.imem_ack;
    assign w_id_free  = !r_id_valid || !stall_i;
    assign w_consume  = r_id_valid && !stall_i;
    assign w_redir    = w_consume && (redirect_sel != 2'b00) && !r_pend;
    assign w_load_mem = w_ack && w_id_free;
    assign w_load_buf = (r_state == ST_HOLD) && !stall_i;

    // The delay slot is accepted at this edge (ack) or already buffered (HOLD):
    // the target can replace pc_q now. Otherwise it waits for the slot's ack.
    always_comb begin
        w_resolve     = 1'b0;
        w_resolve_tgt = w_target;
        if (w_ack && w_redir) begin
            w_resolve     = 1'b1;
            w_resolve_tgt = w_target;
        end else if (w_ack && r_pend) begin
            w_resolve     = 1'b1;
            w_resolve_tgt = r_tgt;
        end else if (w_redir && (r_state == ST_HOLD)) begin
            w_resolve     = 1'b1;
            w_resolve_tgt = w_target;
        end
    end

    assign w_set_pend = w_redir && !w_ack && (r_state != ST_HOLD);

`ifdef FETCH_ALIGN_CHK_EN
    logic r_park;
    logic r_exc_pend;
    logic r_fetch_exc;

    assign w_misalign = w_resolve && (w_resolve_tgt[1:0] != 2'b00);
    assign w_park     = r_park;
    assign w_load_nop = r_exc_pend && w_id_free;
    assign fetch_exc  = r_fetch_exc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_park      <= 1'b0;
            r_exc_pend  <= 1'b0;
            r_fetch_exc <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_park     <= 1'b1;
                r_exc_pend <= 1'b1;
            end else if (w_load_nop) begin
                r_exc_pend <= 1'b0;
            end
            if (w_load_mem || w_load_buf) begin
                r_fetch_exc <= 1'b0;
            end else if (w_load_nop) begin
                r_fetch_exc <= 1'b1;
            end else if (w_consume) begin
                r_fetch_exc <= 1'b0;
            end
        end
    end
`else
    assign w_misalign = 1'b0;
    assign w_park     = 1'b0;
    assign w_load_nop = 1'b0;
    assign fetch_exc  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_park) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_ack) begin
                        if (w_misalign)      r_state <= ST_IDLE;
                        else if (!w_id_free) r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) r_state <= w_misalign ? ST_IDLE : ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc   <= RESET_PC;
            r_pend <= 1'b0;
            r_tgt  <= '0;
        end else begin
            if (w_resolve)  r_pc <= w_resolve_tgt;
            else if (w_ack) r_pc <= r_pc + 32'd4;

            if (w_set_pend) begin
                r_pend <= 1'b1;
                r_tgt  <= w_target;
            end else if (w_ack) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_instr <= '0;
            r_buf_pc    <= RESET_PC;
        end else if (w_ack && !w_id_free) begin
            r_buf_instr <= imem.imem_rdata;
            r_buf_pc    <= r_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= RESET_PC;
        end else if (w_load_mem) begin
            r_id_valid <= 1'b1;
            r_id_instr <= imem.imem_rdata;
            r_id_pc    <= r_pc;
        end else if (w_load_buf) begin
            r_id_valid <= 1'b1;
            r_id_instr <= r_buf_instr;
            r_id_pc    <= r_buf_pc;
        end else if (w_load_nop) begin
            r_id_valid <= 1'b1;
            r_id_instr <= '0;
            r_id_pc    <= r_pc;
        end else if (w_consume) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
        end
    end

    assign imem.imem_req  = (r_state == ST_REQ);
    assign imem.imem_addr = r_pc;
    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc          = r_id_pc;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; instruction words are address ^ K so id_instr is predictable.
module tb_fetch_seq;
    localparam logic [31:0] K = 32'hFEED_0000;

    logic        clk;
    logic        reset_n;
    logic        stall_i;
    logic [1:0]  redirect_sel;
    logic [15:0] br_imm;
    logic [25:0] j_idx;
    logic [31:0] rs_val;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_exc;

    int n_pass  = 0;
    int n_total = 0;

    fetch_seq_if bus();

    fetch_seq #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .redirect_sel (redirect_sel),
        .br_imm       (br_imm),
        .j_idx        (j_idx),
        .rs_val       (rs_val),
        .imem         (bus),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .fetch_exc    (fetch_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    // Advance one edge, settle, then present the memory word for the new address.
    task automatic tick;
        @(posedge clk);
        #1;
        bus.imem_rdata = bus.imem_addr ^ K;
    endtask

    task automatic start;
        reset_n      = 1'b0;
        bus.imem_ack = 1'b1;
        stall_i      = 1'b0;
        redirect_sel = 2'b00;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        bus.imem_ack = 1'b1;
        stall_i      = 1'b0;
        redirect_sel = 2'b00;
        tick;
        tick;
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h3000})
            $display("FAIL reset_bus: got %h required %h", {bus.imem_req, bus.imem_addr}, {1'b0, 32'h3000});
        else n_pass++;
        n_total++;
        if ({id_valid, id_instr, id_pc, fetch_exc} !== {1'b0, 32'h0, 32'h3000, 1'b0})
            $display("FAIL reset_ifid: got %h required %h", {id_valid, id_instr, id_pc, fetch_exc},
                     {1'b0, 32'h0, 32'h3000, 1'b0});
        else n_pass++;
        reset_n = 1'b1;
        tick;
        n_total++;
        if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h3000, 1'b0})
            $display("FAIL reset_first_req: got %h required %h", {bus.imem_req, bus.imem_addr, id_valid},
                     {1'b1, 32'h3000, 1'b0});
        else n_pass++;
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            tick;
            a = 32'h3000 + 32'(4 * i);
            n_total++;
            if ({bus.imem_req, bus.imem_addr, id_valid, id_pc, id_instr} !== {1'b1, a + 32'd4, 1'b1, a, a ^ K})
                $display("FAIL seq_%0d: got %h required %h", i,
                         {bus.imem_req, bus.imem_addr, id_valid, id_pc, id_instr}, {1'b1, a + 32'd4, 1'b1, a, a ^ K});
            else n_pass++;
        end
    endtask

    task automatic test_branch;
        start;
        for (int i = 0; i < 5; i++) tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3010, 32'h3014})
            $display("FAIL br_setup: got %h required %h", {id_pc, bus.imem_addr}, {32'h3010, 32'h3014});
        else n_pass++;
        redirect_sel = 2'b01;
        br_imm       = 16'hFFFC;
        tick;
        redirect_sel = 2'b00;
        n_total++;
        if ({bus.imem_addr, id_pc, id_valid, id_instr} !== {32'h3004, 32'h3014, 1'b1, 32'h3014 ^ K})
            $display("FAIL br_slot: got %h required %h", {bus.imem_addr, id_pc, id_valid, id_instr},
                     {32'h3004, 32'h3014, 1'b1, 32'h3014 ^ K});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3004, 32'h3008})
            $display("FAIL br_target: got %h required %h", {id_pc, bus.imem_addr}, {32'h3004, 32'h3008});
        else n_pass++;
    endtask

    task automatic test_jump;
        start;
        tick;
        redirect_sel = 2'b10;
        j_idx        = 26'h0000C10;
        tick;
        redirect_sel = 2'b00;
        n_total++;
        if ({bus.imem_addr, id_pc, id_valid} !== {32'h3040, 32'h3004, 1'b1})
            $display("FAIL j_slot: got %h required %h", {bus.imem_addr, id_pc, id_valid}, {32'h3040, 32'h3004, 1'b1});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3040, 32'h3044})
            $display("FAIL j_target: got %h required %h", {id_pc, bus.imem_addr}, {32'h3040, 32'h3044});
        else n_pass++;
        redirect_sel = 2'b11;
        rs_val       = 32'h3100;
        tick;
        redirect_sel = 2'b00;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3044, 32'h3100})
            $display("FAIL jr_slot: got %h required %h", {id_pc, bus.imem_addr}, {32'h3044, 32'h3100});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, id_instr, bus.imem_addr} !== {32'h3100, 32'h3100 ^ K, 32'h3104})
            $display("FAIL jr_target: got %h required %h", {id_pc, id_instr, bus.imem_addr},
                     {32'h3100, 32'h3100 ^ K, 32'h3104});
        else n_pass++;
    endtask

    task automatic test_pend;
        start;
        tick;
        bus.imem_ack = 1'b0;
        redirect_sel = 2'b10;
        j_idx        = 26'h0000C10;
        tick;
        redirect_sel = 2'b00;
        n_total++;
        if ({id_valid, id_instr, bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h3004})
            $display("FAIL pend_bubble: got %h required %h", {id_valid, id_instr, bus.imem_req, bus.imem_addr},
                     {1'b0, 32'h0, 1'b1, 32'h3004});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_total++;
            if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h3004, 1'b0})
                $display("FAIL pend_wait_%0d: got %h required %h", i, {bus.imem_req, bus.imem_addr, id_valid},
                         {1'b1, 32'h3004, 1'b0});
            else n_pass++;
        end
        bus.imem_ack = 1'b1;
        tick;
        n_total++;
        if ({id_valid, id_pc, id_instr, bus.imem_addr} !== {1'b1, 32'h3004, 32'h3004 ^ K, 32'h3040})
            $display("FAIL pend_slot: got %h required %h", {id_valid, id_pc, id_instr, bus.imem_addr},
                     {1'b1, 32'h3004, 32'h3004 ^ K, 32'h3040});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3040, 32'h3044})
            $display("FAIL pend_target: got %h required %h", {id_pc, bus.imem_addr}, {32'h3040, 32'h3044});
        else n_pass++;
    endtask

    task automatic test_stall;
        start;
        tick;
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_total++;
            if ({bus.imem_req, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, 32'h3000, 32'h3000 ^ K})
                $display("FAIL stall_hold_%0d: got %h required %h", i, {bus.imem_req, id_valid, id_pc, id_instr},
                         {1'b0, 1'b1, 32'h3000, 32'h3000 ^ K});
            else n_pass++;
        end
        stall_i = 1'b0;
        tick;
        n_total++;
        if ({id_valid, id_pc, id_instr, bus.imem_req, bus.imem_addr} !== {1'b1, 32'h3004, 32'h3004 ^ K, 1'b1, 32'h3008})
            $display("FAIL stall_release: got %h required %h", {id_valid, id_pc, id_instr, bus.imem_req, bus.imem_addr},
                     {1'b1, 32'h3004, 32'h3004 ^ K, 1'b1, 32'h3008});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3008, 32'h300C})
            $display("FAIL stall_resume: got %h required %h", {id_pc, bus.imem_addr}, {32'h3008, 32'h300C});
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        start;
        tick;
        stall_i = 1'b1;
        tick;
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL sim_hold: got %b required %b", bus.imem_req, 1'b0);
        else n_pass++;
        stall_i      = 1'b0;
        redirect_sel = 2'b10;
        j_idx        = 26'h0000C10;
        tick;
        redirect_sel = 2'b00;
        n_total++;
        if ({id_valid, id_pc, bus.imem_req, bus.imem_addr} !== {1'b1, 32'h3004, 1'b1, 32'h3040})
            $display("FAIL sim_release_redirect: got %h required %h", {id_valid, id_pc, bus.imem_req, bus.imem_addr},
                     {1'b1, 32'h3004, 1'b1, 32'h3040});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, bus.imem_addr} !== {32'h3040, 32'h3044})
            $display("FAIL sim_target: got %h required %h", {id_pc, bus.imem_addr}, {32'h3040, 32'h3044});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        start;
        tick;
        tick;
        bus.imem_ack = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, fetch_exc} !==
            {1'b0, 32'h3000, 1'b0, 32'h0, 32'h3000, 1'b0})
            $display("FAIL rmid_async: got %h required %h",
                     {bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, fetch_exc},
                     {1'b0, 32'h3000, 1'b0, 32'h0, 32'h3000, 1'b0});
        else n_pass++;
        bus.imem_ack = 1'b1;
        tick;
        reset_n = 1'b1;
        tick;
        n_total++;
        if ({bus.imem_req, bus.imem_addr, id_valid} !== {1'b1, 32'h3000, 1'b0})
            $display("FAIL rmid_late_ack: got %h required %h", {bus.imem_req, bus.imem_addr, id_valid},
                     {1'b1, 32'h3000, 1'b0});
        else n_pass++;
        tick;
        n_total++;
        if ({id_valid, id_pc, bus.imem_addr} !== {1'b1, 32'h3000, 32'h3004})
            $display("FAIL rmid_restart: got %h required %h", {id_valid, id_pc, bus.imem_addr},
                     {1'b1, 32'h3000, 32'h3004});
        else n_pass++;
    endtask

    task automatic test_align;
        start;
        tick;
        redirect_sel = 2'b11;
        rs_val       = 32'h3102;
        tick;
        redirect_sel = 2'b00;
`ifdef FETCH_ALIGN_CHK_EN
        n_total++;
        if ({bus.imem_req, bus.imem_addr, id_pc} !== {1'b0, 32'h3102, 32'h3004})
            $display("FAIL align_park: got %h required %h", {bus.imem_req, bus.imem_addr, id_pc},
                     {1'b0, 32'h3102, 32'h3004});
        else n_pass++;
        tick;
        n_total++;
        if ({id_valid, id_instr, id_pc, fetch_exc, bus.imem_req} !== {1'b1, 32'h0, 32'h3102, 1'b1, 1'b0})
            $display("FAIL align_nop: got %h required %h", {id_valid, id_instr, id_pc, fetch_exc, bus.imem_req},
                     {1'b1, 32'h0, 32'h3102, 1'b1, 1'b0});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_total++;
            if ({id_valid, fetch_exc, bus.imem_req} !== {1'b0, 1'b0, 1'b0})
                $display("FAIL align_parked_%0d: got %h required %h", i, {id_valid, fetch_exc, bus.imem_req},
                         {1'b0, 1'b0, 1'b0});
            else n_pass++;
        end
`else
        n_total++;
        if ({bus.imem_req, bus.imem_addr, id_pc, fetch_exc} !== {1'b1, 32'h3102, 32'h3004, 1'b0})
            $display("FAIL noalign_fetch: got %h required %h", {bus.imem_req, bus.imem_addr, id_pc, fetch_exc},
                     {1'b1, 32'h3102, 32'h3004, 1'b0});
        else n_pass++;
        tick;
        n_total++;
        if ({id_pc, id_instr, fetch_exc} !== {32'h3102, 32'h3102 ^ K, 1'b0})
            $display("FAIL noalign_load: got %h required %h", {id_pc, id_instr, fetch_exc},
                     {32'h3102, 32'h3102 ^ K, 1'b0});
        else n_pass++;
`endif
    endtask

    initial begin
        reset_n        = 1'b0;
        stall_i        = 1'b0;
        redirect_sel   = 2'b00;
        br_imm         = '0;
        j_idx          = '0;
        rs_val         = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        #2;
        test_reset;
        test_sequential;
        test_branch;
        test_jump;
        test_pend;
        test_stall;
        test_simultaneous;
        test_reset_mid;
        test_align;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
